exec_ctrl: RTL and testbench

Multi-cycle execute sequencer directly upstream of the 8-bit ALU. It accepts one instruction per valid/ready handshake and reads two operands from an internal 4×8-bit register file. It drives the ALU's A, B and ALU_Sel inputs, then captures ALU_Out/CarryOut and writes the result and Zero/Carry flags back. It also handles the load-immediate, divide-by-zero and illegal-opcode cases that the ALU itself does not.

---
 rtl/exec_ctrl.sv | 129 ++++++++++++
 tb/tb_exec_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
// Execute sequencer for the external 8-bit ALU: IDLE -> EXEC -> WB.
// Owns a 4x8 register file, operand/select registers, flags and retirement error status.
module exec_ctrl #(
    parameter int NREGS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] op,
    input  logic [1:0] rd,
    input  logic [1:0] rs1,
    input  logic [1:0] rs2,
    input  logic [7:0] imm,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [3:0] ALU_Sel,
    input  logic [7:0] ALU_Out,
    input  logic       CarryOut,
    output logic       done,
    output logic       err,
    output logic       zero_flag,
    output logic       carry_flag,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    localparam logic [3:0] OP_DIV     = 4'b0011;
    localparam logic [3:0] OP_ALU_MAX = 4'b1010;
    localparam logic [3:0] OP_LDI     = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t     state, state_next;
    logic [7:0] regs [NREGS];
    logic [3:0] op_q;
    logic [1:0] rd_q;
    logic [7:0] imm_q;
    logic       accept;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       flag_en;
    logic       z_next;
    logic       c_next;
    logic       err_next;

    assign instr_ready = (state == S_IDLE);
    assign done        = (state == S_WB);
    assign accept      = instr_valid && instr_ready;
    assign dbg_data    = regs[dbg_sel];

    // NOTE: sequential state is always updated with <=, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of a combinational block is defaulted first, so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_EXEC;
            S_EXEC:  state_next = S_WB;
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Retirement decision for the latched op, evaluated against the registered operands.
    always_comb begin
        wr_en    = 1'b0;
        wr_data  = ALU_Out;
        flag_en  = 1'b0;
        z_next   = (ALU_Out == 8'h00);
        c_next   = CarryOut;
        err_next = 1'b0;
        if (op_q == OP_LDI) begin
            wr_en   = 1'b1;
            wr_data = imm_q;
            flag_en = 1'b1;
            z_next  = (imm_q == 8'h00);
            c_next  = 1'b0;
        end else if ((op_q > OP_ALU_MAX) || ((op_q == OP_DIV) && (ALU_B == 8'h00))) begin
            err_next = 1'b1;
        end else begin
            wr_en   = 1'b1;
            flag_en = 1'b1;
        end
    end

    // NOTE: the register file is tiny and architecturally zero after reset, so it is reset like any flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
            op_q       <= 4'b0000;
            rd_q       <= 2'b00;
            imm_q      <= 8'h00;
            ALU_A      <= 8'h00;
            ALU_B      <= 8'h00;
            ALU_Sel    <= 4'b0000;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op;
                rd_q    <= rd;
                imm_q   <= imm;
                ALU_A   <= regs[rs1];
                ALU_B   <= regs[rs2];
                ALU_Sel <= (op > OP_ALU_MAX) ? 4'b0000 : op;
            end
            if (state == S_EXEC) begin
                if (wr_en) regs[rd_q] <= wr_data;
                if (flag_en) begin
                    zero_flag  <= z_next;
                    carry_flag <= c_next;
                end
                err <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: behavioural ALU + architectural register/flag model,
// directed scenarios followed by randomized instruction streams.
module tb_exec_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] op = '0;
    logic [1:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [7:0] imm = '0;
    logic [7:0] ALU_A, ALU_B, ALU_Out;
    logic [3:0] ALU_Sel;
    logic       CarryOut;
    logic       done, err, zero_flag, carry_flag;
    logic [1:0] dbg_sel = '0;
    logic [7:0] dbg_data;

    int vectors = 0;
    int fails = 0;
    int cyc = 0;
    int n_done = 0;

    logic [7:0] ref_r [4];
    logic       ref_z, ref_c;

    typedef struct {
        int              hs;
        logic [7:0]      a, b;
        logic [3:0]      sel;
        logic            rdy_exec, done_exec, done_wb, errv, z, c, rdy_after, done_after;
        logic [3:0][7:0] r;
    } obs_t;

    exec_ctrl #(.NREGS(4)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .CarryOut(CarryOut),
        .done(done), .err(err), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) n_done <= n_done + 1;

    // Behavioural model of the downstream ALU; carry is always bit 8 of A+B.
    function automatic logic [8:0] alu_fn(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        logic [7:0] r;
        sum = {1'b0, a} + {1'b0, b};
        case (s)
            4'd0:    r = sum[7:0];
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = (b == 8'h00) ? 8'h00 : a / b;
            4'd4:    r = a & b;
            4'd5:    r = a | b;
            4'd6:    r = a ^ b;
            4'd7:    r = ~(a | b);
            4'd8:    r = (a < b) ? 8'hFF : ((a == b) ? 8'h00 : 8'h01);
            4'd9:    r = a << 1;
            4'd10:   r = a >> 1;
            default: r = 8'h00;
        endcase
        return {sum[8], r};
    endfunction

    always_comb {CarryOut, ALU_Out} = alu_fn(ALU_Sel, ALU_A, ALU_B);

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
        ref_z = 1'b0;
        ref_c = 1'b0;
    endtask

    // Architectural effect of one instruction; returns expected ALU drive and err.
    task automatic model_exec(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [7:0] im,
                              output logic [7:0] ea, output logic [7:0] eb,
                              output logic [3:0] es, output logic ee);
        logic [8:0] r;
        ea = ref_r[s1];
        eb = ref_r[s2];
        es = (o <= 4'd10) ? o : 4'd0;
        ee = 1'b0;
        if (o == 4'd15) begin
            ref_r[d] = im;
            ref_z = (im == 8'h00);
            ref_c = 1'b0;
        end else if (o > 4'd10 || (o == 4'd3 && eb == 8'h00)) begin
            ee = 1'b1;
        end else begin
            r = alu_fn(o, ea, eb);
            ref_r[d] = r[7:0];
            ref_z = (r[7:0] == 8'h00);
            ref_c = r[8];
        end
    endtask

    // Drives one instruction from a negedge, observes cycles k+1..k+3, returns at negedge k+3.
    task automatic run_instr(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s1,
                             input logic [1:0] s2, input logic [7:0] im, input logic hold,
                             output obs_t ob);
        ob = '{default: '0};
        ob.hs = -1;
        instr_valid = 1'b1;
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        for (int t = 0; t < 20; t++) begin
            if (instr_ready) begin
                ob.hs = cyc;
                break;
            end
            @(negedge clk);
        end
        if (ob.hs < 0) begin
            instr_valid = 1'b0;
            return;
        end
        @(negedge clk);
        ob.a = ALU_A; ob.b = ALU_B; ob.sel = ALU_Sel;
        ob.rdy_exec = instr_ready; ob.done_exec = done;
        if (!hold) instr_valid = 1'b0;
        @(negedge clk);
        ob.done_wb = done; ob.errv = err; ob.z = zero_flag; ob.c = carry_flag;
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            ob.r[i] = dbg_data;
        end
        @(negedge clk);
        ob.rdy_after = instr_ready; ob.done_after = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", instr_ready); end
        vectors++; if ({done, err, zero_flag, carry_flag} !== 4'b0000) begin fails++; $display("FAIL reset_status: got %b exp 0000", {done, err, zero_flag, carry_flag}); end
        vectors++; if ({ALU_A, ALU_B, ALU_Sel} !== 20'h0) begin fails++; $display("FAIL reset_alu: got %h exp 00000", {ALU_A, ALU_B, ALU_Sel}); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            vectors++; if (dbg_data !== 8'h00) begin fails++; $display("FAIL reset_r%0d: got %h exp 00", i, dbg_data); end
        end
    endtask

    task automatic test_add();
        obs_t ob;
        logic [7:0] ea, eb;
        logic [3:0] es;
        logic ee;
        logic [3:0] ops [3] = '{4'd15, 4'd15, 4'd0};
        logic [1:0] rds [3] = '{2'd0, 2'd1, 2'd2};
        logic [7:0] ims [3] = '{8'hC8, 8'h64, 8'h00};
        for (int i = 0; i < 3; i++) begin
            model_exec(ops[i], rds[i], 2'd0, 2'd1, ims[i], ea, eb, es, ee);
            run_instr(ops[i], rds[i], 2'd0, 2'd1, ims[i], 1'b0, ob);
            vectors++; if (ob.hs < 0) begin fails++; $display("FAIL add_hs%0d: got timeout exp handshake", i); end
            vectors++; if ({ob.rdy_exec, ob.done_exec, ob.done_wb, ob.rdy_after, ob.done_after} !== 5'b00110)
                begin fails++; $display("FAIL add_timing%0d: got %b exp 00110", i, {ob.rdy_exec, ob.done_exec, ob.done_wb, ob.rdy_after, ob.done_after}); end
        end
        vectors++; if (ob.r[2] !== 8'h2C) begin fails++; $display("FAIL add_r2: got %h exp 2c", ob.r[2]); end
        vectors++; if ({ob.c, ob.z, ob.errv} !== 3'b100) begin fails++; $display("FAIL add_flags: got czE=%b exp 100", {ob.c, ob.z, ob.errv}); end
        vectors++; if ({ob.a, ob.b} !== 16'hC864) begin fails++; $display("FAIL add_operands: got %h exp c864", {ob.a, ob.b}); end
    endtask

    task automatic test_cmp_sub();
        obs_t ob;
        logic [7:0] ea, eb;
        logic [3:0] es;
        logic ee;
        model_exec(4'd15, 2'd0, 2'd0, 2'd0, 8'h05, ea, eb, es, ee); run_instr(4'd15, 2'd0, 2'd0, 2'd0, 8'h05, 1'b0, ob);
        model_exec(4'd15, 2'd1, 2'd0, 2'd0, 8'h09, ea, eb, es, ee); run_instr(4'd15, 2'd1, 2'd0, 2'd0, 8'h09, 1'b0, ob);
        model_exec(4'd8, 2'd3, 2'd0, 2'd1, 8'h00, ea, eb, es, ee);  run_instr(4'd8, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0, ob);
        vectors++; if (ob.r[3] !== 8'hFF) begin fails++; $display("FAIL cmp_r3: got %h exp ff", ob.r[3]); end
        vectors++; if (ob.sel !== 4'd8) begin fails++; $display("FAIL cmp_sel: got %h exp 8", ob.sel); end
        model_exec(4'd1, 2'd3, 2'd0, 2'd0, 8'h00, ea, eb, es, ee);  run_instr(4'd1, 2'd3, 2'd0, 2'd0, 8'h00, 1'b0, ob);
        vectors++; if (ob.r[3] !== 8'h00) begin fails++; $display("FAIL sub_r3: got %h exp 00", ob.r[3]); end
        vectors++; if ({ob.z, ob.c, ob.errv} !== 3'b100) begin fails++; $display("FAIL sub_flags: got zcE=%b exp 100", {ob.z, ob.c, ob.errv}); end
    endtask

    task automatic test_div_zero();
        obs_t ob;
        logic [7:0] ea, eb;
        logic [3:0] es;
        logic ee;
        model_exec(4'd15, 2'd1, 2'd0, 2'd0, 8'h00, ea, eb, es, ee); run_instr(4'd15, 2'd1, 2'd0, 2'd0, 8'h00, 1'b0, ob);
        model_exec(4'd15, 2'd2, 2'd0, 2'd0, 8'h77, ea, eb, es, ee); run_instr(4'd15, 2'd2, 2'd0, 2'd0, 8'h77, 1'b0, ob);
        model_exec(4'd15, 2'd3, 2'd0, 2'd0, 8'hFF, ea, eb, es, ee); run_instr(4'd15, 2'd3, 2'd0, 2'd0, 8'hFF, 1'b0, ob);
        model_exec(4'd0, 2'd3, 2'd3, 2'd3, 8'h00, ea, eb, es, ee);  run_instr(4'd0, 2'd3, 2'd3, 2'd3, 8'h00, 1'b0, ob);
        vectors++; if ({ob.r[3], ob.c} !== 9'h1FD) begin fails++; $display("FAIL ff_plus_ff: got %h exp 1fd", {ob.r[3], ob.c}); end
        model_exec(4'd3, 2'd2, 2'd0, 2'd1, 8'h00, ea, eb, es, ee);  run_instr(4'd3, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0, ob);
        vectors++; if ({ob.done_wb, ob.errv} !== 2'b11) begin fails++; $display("FAIL div0_err: got done/err %b exp 11", {ob.done_wb, ob.errv}); end
        vectors++; if (ob.r[2] !== 8'h77) begin fails++; $display("FAIL div0_r2: got %h exp 77", ob.r[2]); end
        vectors++; if ({ob.z, ob.c} !== 2'b01) begin fails++; $display("FAIL div0_flags: got zc=%b exp 01", {ob.z, ob.c}); end
        model_exec(4'd5, 2'd0, 2'd0, 2'd1, 8'h00, ea, eb, es, ee);  run_instr(4'd5, 2'd0, 2'd0, 2'd1, 8'h00, 1'b0, ob);
        vectors++; if (ob.errv !== 1'b0) begin fails++; $display("FAIL div0_recover: got err %b exp 0", ob.errv); end
    endtask

    task automatic test_illegal();
        obs_t ob;
        logic [7:0] ea, eb;
        logic [3:0] es;
        logic ee;
        model_exec(4'd1, 2'd1, 2'd0, 2'd0, 8'h00, ea, eb, es, ee);  run_instr(4'd1, 2'd1, 2'd0, 2'd0, 8'h00, 1'b0, ob);
        model_exec(4'd12, 2'd0, 2'd2, 2'd3, 8'h5A, ea, eb, es, ee); run_instr(4'd12, 2'd0, 2'd2, 2'd3, 8'h5A, 1'b0, ob);
        vectors++; if (ob.sel !== 4'd0) begin fails++; $display("FAIL illegal_sel: got %h exp 0", ob.sel); end
        vectors++; if ({ob.done_wb, ob.errv} !== 2'b11) begin fails++; $display("FAIL illegal_err: got done/err %b exp 11", {ob.done_wb, ob.errv}); end
        vectors++; if ({ob.z, ob.c} !== {ref_z, ref_c} || ref_z !== 1'b1) begin fails++; $display("FAIL illegal_flags: got zc=%b exp 10", {ob.z, ob.c}); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (ob.r[i] !== ref_r[i]) begin fails++; $display("FAIL illegal_r%0d: got %h exp %h", i, ob.r[i], ref_r[i]); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t ob;
        logic [7:0] ea, eb;
        logic [3:0] es;
        logic ee;
        int prev_hs = 0;
        int done0 = n_done;
        logic [3:0] ops [4] = '{4'd15, 4'd0, 4'd6, 4'd9};
        logic [1:0] rds [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            model_exec(ops[i], rds[i], 2'd1, 2'd2, 8'hA5, ea, eb, es, ee);
            run_instr(ops[i], rds[i], 2'd1, 2'd2, 8'hA5, (i < 3), ob);
            vectors++; if (ob.hs < 0 || (i > 0 && ob.hs - prev_hs != 3)) begin fails++; $display("FAIL b2b_spacing%0d: got %0d exp 3", i, ob.hs - prev_hs); end
            vectors++; if ({ob.rdy_exec, ob.done_wb} !== 2'b01) begin fails++; $display("FAIL b2b_ready%0d: got rdy/done %b exp 01", i, {ob.rdy_exec, ob.done_wb}); end
            vectors++; if ({ob.a, ob.b} !== {ea, eb}) begin fails++; $display("FAIL b2b_ops%0d: got %h exp %h", i, {ob.a, ob.b}, {ea, eb}); end
            prev_hs = ob.hs;
        end
        repeat (4) @(negedge clk);
        vectors++; if (n_done - done0 != 4) begin fails++; $display("FAIL b2b_count: got %0d exp 4", n_done - done0); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            vectors++; if (dbg_data !== ref_r[i]) begin fails++; $display("FAIL b2b_r%0d: got %h exp %h", i, dbg_data, ref_r[i]); end
        end
    endtask

    task automatic test_random();
        obs_t ob;
        logic [7:0] ea, eb;
        logic [3:0] es;
        logic ee;
        logic [3:0] o;
        logic [1:0] d, s1, s2;
        logic [7:0] im;
        for (int n = 0; n < 40; n++) begin
            o = 4'($urandom_range(0, 15));
            d = 2'($urandom); s1 = 2'($urandom); s2 = 2'($urandom); im = 8'($urandom);
            if (n % 8 == 0) im = 8'h00;
            model_exec(o, d, s1, s2, im, ea, eb, es, ee);
            run_instr(o, d, s1, s2, im, 1'b0, ob);
            vectors++; if (ob.hs < 0) begin fails++; $display("FAIL rnd%0d_hs: got timeout exp handshake", n); end
            vectors++; if ({ob.a, ob.b, ob.sel} !== {ea, eb, es}) begin fails++; $display("FAIL rnd%0d_alu: got %h exp %h", n, {ob.a, ob.b, ob.sel}, {ea, eb, es}); end
            vectors++; if ({ob.rdy_exec, ob.done_exec, ob.done_wb, ob.rdy_after, ob.done_after} !== 5'b00110)
                begin fails++; $display("FAIL rnd%0d_timing: got %b exp 00110", n, {ob.rdy_exec, ob.done_exec, ob.done_wb, ob.rdy_after, ob.done_after}); end
            vectors++; if ({ob.errv, ob.z, ob.c} !== {ee, ref_z, ref_c}) begin fails++; $display("FAIL rnd%0d_status op=%h: got ezc=%b exp %b", n, o, {ob.errv, ob.z, ob.c}, {ee, ref_z, ref_c}); end
            for (int i = 0; i < 4; i++) begin
                vectors++; if (ob.r[i] !== ref_r[i]) begin fails++; $display("FAIL rnd%0d_r%0d op=%h: got %h exp %h", n, i, o, ob.r[i], ref_r[i]); end
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        obs_t ob;
        logic [7:0] ea, eb;
        logic [3:0] es;
        logic ee;
        int done0;
        int hs = -1;
        model_exec(4'd15, 2'd0, 2'd0, 2'd0, 8'hC8, ea, eb, es, ee); run_instr(4'd15, 2'd0, 2'd0, 2'd0, 8'hC8, 1'b0, ob);
        model_exec(4'd15, 2'd1, 2'd0, 2'd0, 8'h64, ea, eb, es, ee); run_instr(4'd15, 2'd1, 2'd0, 2'd0, 8'h64, 1'b0, ob);
        instr_valid = 1'b1; op = 4'd0; rd = 2'd2; rs1 = 2'd0; rs2 = 2'd1;
        for (int t = 0; t < 20; t++) begin
            if (instr_ready) begin hs = cyc; break; end
            @(negedge clk);
        end
        vectors++; if (hs < 0) begin fails++; $display("FAIL abort_hs: got timeout exp handshake"); end
        @(negedge clk);
        done0 = n_done;
        reset = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done_in_reset: got %b exp 0", done); end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b exp 1", instr_ready); end
        vectors++; if ({zero_flag, carry_flag, err} !== 3'b000) begin fails++; $display("FAIL abort_flags: got %b exp 000", {zero_flag, carry_flag, err}); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            vectors++; if (dbg_data !== 8'h00) begin fails++; $display("FAIL abort_r%0d: got %h exp 00", i, dbg_data); end
        end
        repeat (3) @(negedge clk);
        vectors++; if (n_done != done0) begin fails++; $display("FAIL abort_no_done: got %0d pulses exp 0", n_done - done0); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_cmp_sub();
        test_div_zero();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
